seq_divmod: RTL and testbench

Multi-cycle, parametrised integer divider producing quotient and remainder together from a start/done handshake. It is the sequential successor to the combinational modulus component and is used where a single-cycle `%` or `/` of width DATAWIDTH would dominate the critical path. It computes one quotient bit per clock using restoring division. It flags divide-by-zero, and optionally supports signed operands.

---
 rtl/seq_divmod.sv | 171 +++++++++++++++++
 tb/tb_seq_divmod.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divmod.sv
// seq_divmod: restoring divider, one quotient bit per clock, quot+rem.
// Define DIVMOD_SIGNED_EN for two's-complement (truncating) operands.
module seq_divmod #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] quot,
  output logic [DATAWIDTH-1:0] rem,
  output logic                 div_by_zero
);

  localparam int W  = DATAWIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   dvd_q, dvd_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [W-1:0]   prem_q, prem_d;
  logic [W-1:0]   quot_q, quot_d;
  logic [W-1:0]   rem_q, rem_d;
  logic           dbz_q, dbz_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [W:0]     shft;
  logic [W:0]     trial;
  logic           qbit;
  logic [W-1:0]   q_mag;
  logic [W-1:0]   r_mag;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W-1:0]   q_fin;
  logic [W-1:0]   r_fin;

`ifdef DIVMOD_SIGNED_EN
  logic           sa_q, sa_d;
  logic           sq_q, sq_d;
`endif

  // One restoring step plus operand/result sign handling
  always_comb begin
    shft  = {prem_q, dvd_q[W-1]};
    trial = shft - {1'b0, dvs_q};
    qbit  = ~trial[W];
    q_mag = {dvd_q[W-2:0], qbit};
    r_mag = qbit ? trial[W-1:0] : shft[W-1:0];
`ifdef DIVMOD_SIGNED_EN
    a_mag = a[W-1] ? -a : a;
    b_mag = b[W-1] ? -b : b;
    q_fin = sq_q ? -q_mag : q_mag;
    r_fin = sa_q ? -r_mag : r_mag;
`else
    a_mag = a;
    b_mag = b;
    q_fin = q_mag;
    r_fin = r_mag;
`endif
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef DIVMOD_SIGNED_EN
    sa_d    = sa_q;
    sq_d    = sq_q;
`endif
    case (state_q)
      S_CALC: begin
        prem_d = r_mag;
        dvd_d  = q_mag;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = S_DONE;
          quot_d  = q_fin;
          rem_d   = r_fin;
          dbz_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (start) begin
          if (b == '0) begin
            state_d = S_DONE;
            quot_d  = '1;
            rem_d   = a;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_CALC;
            dvd_d   = a_mag;
            dvs_d   = b_mag;
            prem_d  = '0;
            cnt_d   = '0;
`ifdef DIVMOD_SIGNED_EN
            sa_d    = a[W-1];
            sq_d    = a[W-1] ^ b[W-1];
`endif
          end
        end
      end
    endcase
    busy_d = (state_d == S_CALC);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef DIVMOD_SIGNED_EN
  // Operand sign registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sa_q <= 1'b0;
      sq_q <= 1'b0;
    end else begin
      sa_q <= sa_d;
      sq_q <= sq_d;
    end
  end
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign quot        = quot_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divmod.sv
// tb_seq_divmod: scoreboard bench for seq_divmod, DATAWIDTH=8.
// Expected results are queued at accept and popped on done.
module tb_seq_divmod;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } res_t;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quot, rem;

  int   nvec = 0;
  int   nerr = 0;
  res_t sb[$];
  res_t last;
  int   mst;
  int   mcnt;

  seq_divmod #(.DATAWIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .quot(quot), .rem(rem),
    .div_by_zero(div_by_zero)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic res_t ref_div(input logic [W-1:0] x,
                                   input logic [W-1:0] y);
    res_t o;
    logic signed [W-1:0] sx, sy;
    sx = x;
    sy = y;
    if (y == '0) begin
      o.q = '1;
      o.r = x;
      o.z = 1'b1;
    end else begin
      o.z = 1'b0;
`ifdef DIVMOD_SIGNED_EN
      if (x == 8'h80 && y == 8'hFF) begin
        o.q = 8'h80;
        o.r = '0;
      end else begin
        o.q = sx / sy;
        o.r = sx % sy;
      end
`else
      o.q = x / y;
      o.r = x % y;
`endif
    end
    return o;
  endfunction

  // Reference sequencer: 0 idle, 1 calc, 2 done
  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mst  = 0;
      mcnt = 0;
      last = '0;
      sb.delete();
    end else if (mst == 1) begin
      mcnt++;
      if (mcnt == W) mst = 2;
    end else if (start) begin
      sb.push_back(ref_div(a, b));
      mcnt = 0;
      mst  = (b == '0) ? 2 : 1;
    end else begin
      mst = 0;
    end
  end

  // Output monitor, sampled mid-cycle
  always @(negedge Clk) begin
    res_t e;
    check("busy", busy, mst == 1);
    check("done", done, mst == 2);
    check("busy_done_excl", busy & done, 0);
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        last = e;
      end
    end
    check("quot", quot, last.q);
    check("rem", rem, last.r);
    check("dbz", div_by_zero, last.z);
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (mst != 0 && n < 40) begin
      @(posedge Clk);
      #1;
      n++;
    end
    if (n >= 40) check("idle_timeout", 1, 0);
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    wait_idle();
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quot", quot, 0);
    check("rst_rem", rem, 0);
    check("rst_dbz", div_by_zero, 0);
    Rst = 1'b0;
    @(posedge Clk);
    #1;

`ifdef DIVMOD_SIGNED_EN
    run_op(8'hF9, 8'h02);
    check("s_m7_2_q", quot, 8'hFD);
    check("s_m7_2_r", rem, 8'hFF);
    run_op(8'h07, 8'hFE);
    check("s_7_m2_q", quot, 8'hFD);
    check("s_7_m2_r", rem, 8'h01);
    run_op(8'h80, 8'hFF);
    check("s_min_q", quot, 8'h80);
    check("s_min_r", rem, 8'h00);
    run_op(8'h2A, 8'h00);
    check("s_dz_q", quot, 8'hFF);
`else
    run_op(8'd100, 8'd7);
    check("d100_7_q", quot, 14);
    check("d100_7_r", rem, 2);
    run_op(8'd255, 8'd1);
    check("d255_1_q", quot, 255);
    run_op(8'd3, 8'd200);
    check("d3_200_r", rem, 3);
    run_op(8'd42, 8'd0);
    check("dz_q", quot, 255);
    check("dz_r", rem, 42);
    check("dz_flag", div_by_zero, 1);
    run_op(8'd42, 8'd6);
    check("d42_6_q", quot, 7);
    check("d42_6_flag", div_by_zero, 0);
`endif

    // start held high with operands changing every cycle
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      b = (i == 20) ? 8'd0 : 8'($urandom_range(1, 255));
      @(posedge Clk);
      #1;
    end
    start = 1'b0;
    wait_idle();

    // reset four cycles into a calculation
    a     = 8'd200;
    b     = 8'd3;
    start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quot", quot, 0);
    check("abort_rem", rem, 0);
    check("abort_dbz", div_by_zero, 0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    run_op(8'd77, 8'd5);

    // random operands, including edges
    run_op(8'd0, 8'd1);
    run_op(8'd1, 8'd255);
    run_op(8'd255, 8'd255);
    run_op(8'h80, 8'hFF);
    for (int i = 0; i < 15; i++) begin
      run_op(8'($urandom), 8'($urandom));
    end

    repeat (2) @(posedge Clk);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
